// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bubble encoding, reset PC default, word-align mask
// and the IF/ID payload layout used by fetch and decode.
package pipeline_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

   // IF/ID pipeline register payload
   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

   // Canonical bubble: NOP, no link value, marked invalid
   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b.inst     = NOP_INST;
      b.pc_plus4 = '0;
      b.valid    = 1'b0;
      return b;
   endfunction

   // Decode-side bubble detection
   function automatic logic is_bubble(if_id_t r);
      return !r.valid;
   endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: branch > jr > jump > stall-hold > PC+4, targets word-aligned.
import pipeline_pkg::*;

module fetch_pc_sel (
   input  logic [XLEN-1:0] pc,
   input  logic            stall,
   input  logic            id_jump,
   input  logic [XLEN-1:0] id_jump_target,
   input  logic            id_jr,
   input  logic [XLEN-1:0] id_jr_target,
   input  logic            ex_branch_taken,
   input  logic [XLEN-1:0] ex_branch_target,
   output logic [XLEN-1:0] pc_plus4_c,
   output logic [XLEN-1:0] next_pc_c,
   output logic            redirect_c
);

   // Sequential address, modulo 2^32
   assign pc_plus4_c = pc + XLEN'(4);

   // Any control transfer squashes the instruction being fetched
   assign redirect_c = ex_branch_taken | id_jr | id_jump;

   // Priority select; redirects override a stall
   always_comb begin
      next_pc_c = pc_plus4_c;
      if (ex_branch_taken) begin
         next_pc_c = ex_branch_target & WORD_ALIGN_MASK;
      end else if (id_jr) begin
         next_pc_c = id_jr_target & WORD_ALIGN_MASK;
      end else if (id_jump) begin
         next_pc_c = id_jump_target & WORD_ALIGN_MASK;
      end else if (stall) begin
         next_pc_c = pc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address, IF/ID register.
// Optional macro FETCH_BOUND_CHECK_EN adds a sticky fetch_fault output that
// bubbles fetches beyond IMEM_WORDS.
import pipeline_pkg::*;

module fetch_stage #(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_WORDS = 256
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_inst,
   input  logic            stall,
   input  logic            id_jump,
   input  logic [XLEN-1:0] id_jump_target,
   input  logic            id_jr,
   input  logic [XLEN-1:0] id_jr_target,
   input  logic            ex_branch_taken,
   input  logic [XLEN-1:0] ex_branch_target,
`ifdef FETCH_BOUND_CHECK_EN
   output logic            fetch_fault,
`endif
   output logic [XLEN-1:0] if_id_inst,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic            if_id_valid
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] next_pc_c;
   logic [XLEN-1:0] pc_plus4_c;
   logic            redirect_c;
   if_id_t          if_id_q;
   if_id_t          if_id_d;

   fetch_pc_sel u_pc_sel (
      .pc               (pc_q),
      .stall            (stall),
      .id_jump          (id_jump),
      .id_jump_target   (id_jump_target),
      .id_jr            (id_jr),
      .id_jr_target     (id_jr_target),
      .ex_branch_taken  (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
      .pc_plus4_c       (pc_plus4_c),
      .next_pc_c        (next_pc_c),
      .redirect_c       (redirect_c)
   );

`ifdef FETCH_BOUND_CHECK_EN
   logic fault_q;
   logic fault_d;
   logic out_of_range_c;

   // Word index of the current fetch lies beyond the instruction memory
   assign out_of_range_c = ({2'b00, pc_q[XLEN-1:2]} >= XLEN'(IMEM_WORDS));

   // IF/ID next value with out-of-range fetches turned into bubbles
   always_comb begin
      if_id_d = if_id_q;
      fault_d = fault_q;
      if (redirect_c) begin
         if_id_d = if_id_bubble();
      end else if (!stall) begin
         if (out_of_range_c) begin
            if_id_d = if_id_bubble();
            fault_d = 1'b1;
         end else begin
            if_id_d.inst     = imem_inst;
            if_id_d.pc_plus4 = pc_plus4_c;
            if_id_d.valid    = 1'b1;
         end
      end
   end

   // Sticky fault flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) fault_q <= 1'b0;
      else        fault_q <= fault_d;
   end

   assign fetch_fault = fault_q;
`else
   localparam int unsigned unused_imem_words = IMEM_WORDS;

   // IF/ID next value: bubble on redirect, hold on stall, else capture fetch
   always_comb begin
      if_id_d = if_id_q;
      if (redirect_c) begin
         if_id_d = if_id_bubble();
      end else if (!stall) begin
         if_id_d.inst     = imem_inst;
         if_id_d.pc_plus4 = pc_plus4_c;
         if_id_d.valid    = 1'b1;
      end
   end
`endif

   // PC and IF/ID registers; reset clears both regardless of hazards
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_PC & WORD_ALIGN_MASK;
         if_id_q <= if_id_bubble();
      end else begin
         pc_q    <= next_pc_c;
         if_id_q <= if_id_d;
      end
   end

   assign imem_addr      = pc_q;
   assign if_id_inst     = if_id_q.inst;
   assign if_id_pc_plus4 = if_id_q.pc_plus4;
   assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus reset, wrap and bound-check sequences.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall;
   logic        id_jump;
   logic [31:0] id_jump_target;
   logic        id_jr;
   logic [31:0] id_jr_target;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
`ifdef FETCH_BOUND_CHECK_EN
   logic        fetch_fault;
`endif

   int tests;
   int failed;

   logic [31:0] mem [256];

   fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_addr        (imem_addr),
      .imem_inst        (imem_inst),
      .stall            (stall),
      .id_jump          (id_jump),
      .id_jump_target   (id_jump_target),
      .id_jr            (id_jr),
      .id_jr_target     (id_jr_target),
      .ex_branch_taken  (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
`ifdef FETCH_BOUND_CHECK_EN
      .fetch_fault      (fetch_fault),
`endif
      .if_id_inst       (if_id_inst),
      .if_id_pc_plus4   (if_id_pc_plus4),
      .if_id_valid      (if_id_valid)
   );

   assign imem_inst = mem[imem_addr[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        jp;
      logic [31:0] jt;
      logic        jr;
      logic [31:0] jrt;
      logic        br;
      logic [31:0] bt;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
      logic [31:0] e_pc4;
      logic        e_valid;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   function automatic logic [31:0] memv(int i);
      return (i == 0) ? 32'h2004_0005 : (32'hA000_0000 | 32'(i));
   endfunction

   function automatic vec_t mk(logic st, logic jp, logic [31:0] jt, logic jr, logic [31:0] jrt,
                               logic br, logic [31:0] bt, logic [31:0] ea, logic [31:0] ei,
                               logic [31:0] ep, logic ev);
      vec_t v;
      v.st = st; v.jp = jp; v.jt = jt; v.jr = jr; v.jrt = jrt; v.br = br; v.bt = bt;
      v.e_addr = ea; v.e_inst = ei; v.e_pc4 = ep; v.e_valid = ev;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic jp, input logic [31:0] jt, input logic jr,
                        input logic [31:0] jrt, input logic br, input logic [31:0] bt);
      stall = st; id_jump = jp; id_jump_target = jt; id_jr = jr; id_jr_target = jrt;
      ex_branch_taken = br; ex_branch_target = bt;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string nm, input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic ev);
      chk({nm, " addr"}, imem_addr, ea);
      chk({nm, " valid"}, 32'(if_id_valid), 32'(ev));
      chk({nm, " inst"}, if_id_inst, ei);
      if (ev) chk({nm, " pc4"}, if_id_pc_plus4, ep);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      idle();
      #1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0000;

   initial begin
      tests  = 0;
      failed = 0;
      for (int i = 0; i < 256; i++) mem[i] = memv(i);

      vecs[0]  = mk(0, 0, 0,      0, 0,      0, 0,     32'h04, memv(0), 32'h04, 1);
      vecs[1]  = mk(0, 0, 0,      0, 0,      0, 0,     32'h08, memv(1), 32'h08, 1);
      vecs[2]  = mk(0, 0, 0,      0, 0,      0, 0,     32'h0C, memv(2), 32'h0C, 1);
      vecs[3]  = mk(0, 1, 32'h10, 0, 0,      0, 0,     32'h10, NOP,     32'h00, 0);
      vecs[4]  = mk(0, 0, 0,      0, 0,      0, 0,     32'h14, memv(4), 32'h14, 1);
      vecs[5]  = mk(0, 0, 0,      0, 0,      0, 0,     32'h18, memv(5), 32'h18, 1);
      vecs[6]  = mk(1, 0, 0,      0, 0,      0, 0,     32'h18, memv(5), 32'h18, 1);
      vecs[7]  = mk(1, 0, 0,      0, 0,      0, 0,     32'h18, memv(5), 32'h18, 1);
      vecs[8]  = mk(0, 0, 0,      0, 0,      0, 0,     32'h1C, memv(6), 32'h1C, 1);
      vecs[9]  = mk(0, 0, 0,      0, 0,      0, 0,     32'h20, memv(7), 32'h20, 1);
      vecs[10] = mk(1, 1, 32'h40, 0, 0,      1, 32'hC, 32'h0C, NOP,     32'h00, 0);
      vecs[11] = mk(0, 1, 32'h80, 1, 32'h23, 0, 0,     32'h20, NOP,     32'h00, 0);
      vecs[12] = mk(0, 0, 0,      0, 0,      0, 0,     32'h24, memv(8), 32'h24, 1);
      vecs[13] = mk(1, 0, 0,      1, 32'h30, 0, 0,     32'h30, NOP,     32'h00, 0);
      vecs[14] = mk(1, 0, 0,      0, 0,      0, 0,     32'h30, NOP,     32'h00, 0);

      // Reset asserted from time zero
      reset = 1'b0;
      idle();
      #2;
      check_state("reset", 32'h0, NOP, 32'h0, 1'b0);
      chk("reset pc4", if_id_pc_plus4, 32'h0);
`ifdef FETCH_BOUND_CHECK_EN
      chk("reset fault", 32'(fetch_fault), 32'h0);
`endif
      @(negedge clk);
      reset = 1'b1;

      // Table-driven main sequence
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].st, vecs[i].jp, vecs[i].jt, vecs[i].jr, vecs[i].jrt, vecs[i].br, vecs[i].bt);
         tick();
         check_state($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_inst, vecs[i].e_pc4,
                     vecs[i].e_valid);
      end

      // Mid-cycle asynchronous reset while stalled at 0x30
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #3;
      reset = 1'b0;
      #1;
      check_state("async rst", 32'h0, NOP, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      tick();
      check_state("rst hold", 32'h0, NOP, 32'h0, 1'b0);
      idle();
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_state("post rst", 32'h04, memv(0), 32'h04, 1'b1);

`ifdef FETCH_BOUND_CHECK_EN
      // Jump beyond the memory: fault one edge after 0x400 is presented
      pulse_reset();
      drive(1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_state("bnd jump", 32'h400, NOP, 32'h0, 1'b0);
      chk("bnd fault0", 32'(fetch_fault), 32'h0);
      idle();
      tick();
      check_state("bnd oor", 32'h404, NOP, 32'h0, 1'b0);
      chk("bnd fault1", 32'(fetch_fault), 32'h1);
      tick();
      check_state("bnd oor2", 32'h408, NOP, 32'h0, 1'b0);
      chk("bnd sticky", 32'(fetch_fault), 32'h1);
`endif

      // PC wrap: jump to top word (misaligned target), then +4 wraps to 0
      pulse_reset();
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_state("wrap jump", 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
      idle();
      tick();
`ifdef FETCH_BOUND_CHECK_EN
      check_state("wrap", 32'h0, NOP, 32'h0, 1'b0);
      chk("wrap fault", 32'(fetch_fault), 32'h1);
`else
      check_state("wrap", 32'h0, memv(255), 32'h0, 1'b1);
`endif
      tick();
      check_state("wrap next", 32'h04, memv(0), 32'h04, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the fetch address into the combinational instruction memory, which decodes word index Address[9:2].
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles sequential PC+4, jump/branch/jr redirects, load-use stalls and control-hazard flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- IMEM_WORDS, 256, instruction-memory depth in words; used only by the optional bound check.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- imem_addr  out  32  fetch address to instruction memory; equals the PC register.
- imem_inst  in  32  instruction returned combinationally for imem_addr.
- stall  in  1  load-use hazard from ID; holds the PC and IF/ID.
- id_jump  in  1  J/JAL decoded in ID this cycle.
- id_jump_target  in  32  {pc_plus4[31:28], instr_index, 2'b00}.
- id_jr  in  1  JR decoded in ID; target already forwarded.
- id_jr_target  in  32  register value for JR.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_branch_target  in  32  branch target address.
- if_id_inst  out  32  instruction presented to ID.
- if_id_pc_plus4  out  32  PC+4 of that instruction (JAL link value, branch base).
- if_id_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, reset==0):
  - PC <= RESET_PC.
  - if_id_inst <= 32'h0000_0000 (NOP).
  - if_id_pc_plus4 <= 0.
  - if_id_valid <= 0.
  - Values take effect immediately, without a clock edge; release is sampled on the next rising edge.
- imem_addr = PC, purely registered, with no combinational path from any input. Fetch latency: the instruction is visible on if_id_inst one edge after its PC is presented.
- Next-PC priority, highest first:
  1. ex_branch_taken -> ex_branch_target
  2. id_jr -> id_jr_target
  3. id_jump -> id_jump_target
  4. stall -> PC held
  5. otherwise PC+4
- Redirect beats stall: a taken branch or jump/jr with stall=1 still updates the PC. The instruction stalled in ID is wrong-path and is squashed downstream.
- IF/ID update each edge:
  - ex_branch_taken=1: load bubble (inst=0, valid=0). This kills the instruction fetched this cycle; ID/EX squash is done elsewhere.
  - Else id_jr or id_jump: load bubble. One delay-slot-free penalty cycle.
  - Else stall=1: hold all IF/ID fields unchanged.
  - Else: if_id_inst <= imem_inst, if_id_pc_plus4 <= PC+4, if_id_valid <= 1.
- Arithmetic: PC+4 is 32-bit modulo and wraps 32'hFFFF_FFFC -> 0. Targets are used as given; bits [1:0] are forced to 0 before loading the PC.
- Branch penalty is 2 bubbles (IF/ID plus the ID stage squashed externally). Jump penalty is 1 bubble.
- Reset mid-operation clears the PC and IF/ID regardless of stall or redirect.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- With the macro defined:
  - Extra output port fetch_fault (1 bit, reset 0).
  - When a non-bubble fetch would be captured with PC[31:2] >= IMEM_WORDS, IF/ID loads a bubble and fetch_fault is set sticky until reset.
  - The PC still advances normally.
- Without the macro: no fetch_fault port; out-of-range fetches capture whatever imem_inst returns (memory default NOP).

Decomposition:
- Shared package pipeline_pkg holds:
  - NOP_INST = 32'h0000_0000
  - RESET_PC default
  - Word-align mask constant
- The decode stage uses the same package for bubble detection.
- One sub-module, fetch_pc_sel: combinational next-PC priority mux with alignment forcing. The PC register and IF/ID register stay in fetch_stage.

Test Plan:
- Reset low, release, free-run with the standard test program:
  - imem_addr sequence is 0, 4, 8.
  - if_id_inst = 32'h2004_0005 one edge after addr 0, with if_id_pc_plus4=4 and valid=1.
- id_jump=1 with target 32'h10 while PC=0xC:
  - Next imem_addr=0x10.
  - IF/ID is a bubble (inst=0, valid=0) for exactly 1 cycle.
- stall=1 for 2 cycles at PC=0x18:
  - imem_addr holds 0x18.
  - if_id_inst is unchanged both cycles.
  - Fetch resumes at 0x1C afterwards.
- ex_branch_taken=1 (target 0xC) together with stall=1 and id_jump=1:
  - PC becomes 0xC (branch wins).
  - IF/ID is a bubble.
- Assert reset low mid-cycle while PC=0x30 and stall=1:
  - imem_addr=0 and valid=0 immediately, before any clock edge.
- FETCH_BOUND_CHECK_EN defined, IMEM_WORDS=256, jump to 0x400:
  - fetch_fault rises one edge later and stays 1.
  - if_id_valid=0.
